// File: rtl/multiply_unit.sv
// rtl/multiply_unit.sv - HI/LO multiply/divide unit with a fixed-latency busy window
// Results come from operands latched at accept and are committed on the final RUN edge.
module multiply_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        load_HI,
  input  logic        load_LO,
  input  logic [31:0] load_value,
  output logic        busy,
  output logic        busy_any,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        accept, done, last;

  // op[1] selects the divide family, which runs twice as long.
  assign last = (cnt == (op_q[1] ? 4'd9 : 4'd4));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      end
      RUN: begin
        cnt_nxt = cnt + 4'd1;
        if (last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= OP_MULT;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  assign busy     = (state == RUN);
  assign busy_any = start | busy;

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide works on magnitudes; the remainder takes the dividend's sign.
  logic        signed_div, a_neg, b_neg, div_zero;
  logic [31:0] dvd, dvs, dvs_safe, quo_u, rem_u, quo, rem;

  assign signed_div = (op_q == OP_DIV);
  assign a_neg      = signed_div & a_q[31];
  assign b_neg      = signed_div & b_q[31];
  assign dvd        = a_neg ? (~a_q + 32'd1) : a_q;
  assign dvs        = b_neg ? (~b_q + 32'd1) : b_q;
  assign div_zero   = (b_q == 32'd0);
  assign dvs_safe   = div_zero ? 32'd1 : dvs;
  assign quo_u      = dvd / dvs_safe;
  assign rem_u      = dvd % dvs_safe;
  assign quo        = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
  assign rem        = a_neg ? (~rem_u + 32'd1) : rem_u;

  logic [31:0] res_hi, res_lo;
  logic        write_res;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV,
      OP_DIVU: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: ;
    endcase
  end

  assign write_res = done & ~(op_q[1] & div_zero);

  // A completing result wins over a same-edge load; an accepted start swallows loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (write_res) begin
      HI <= res_hi;
      LO <= res_lo;
    end else if (!accept) begin
      if (load_HI) HI <= load_value;
      if (load_LO) LO <= load_value;
    end
  end

endmodule

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed below in this order.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin an operation; driven by the WB submitter's calculate.
REQ-005 op  input  2  operation select, sampled with start: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 A  input  32  operand rs, sampled with start; the dividend for div/divu.
REQ-007 B  input  32  operand rt, sampled with start; the divisor for div/divu.
REQ-008 load_HI  input  1  mthi write request.
REQ-009 load_LO  input  1  mtlo write request.
REQ-010 load_value  input  32  data for load_HI and load_LO.
REQ-011 busy  output  1  operation in progress.
REQ-012 busy_any  output  1  combinational start | busy, used for the ID-stage stall.
REQ-013 HI  output  32  architectural HI register.
REQ-014 LO  output  32  architectural LO register.

Function
REQ-015 State machine:
- States: IDLE and RUN.
- IDLE -> RUN on an edge with start=1.
- RUN -> IDLE on the edge where the cycle counter reaches N-1.
REQ-016 Latency:
- N=5 for mult/multu; N=10 for div/divu.
- start sampled at edge k -> busy=1 during cycles k+1 .. k+N.
- HI/LO are written at the edge closing cycle k+N.
- busy=0 and the new HI/LO are visible from cycle k+N+1.
REQ-017 The cycle counter SHALL be 4 bits, cleared on accept, and incremented once per RUN cycle; it SHALL hold in IDLE.
REQ-018 A, B and op SHALL be latched on accept; later changes on these inputs SHALL NOT affect the result.
REQ-019 mult: {HI,LO} = signed(A) * signed(B), full 64-bit product.
REQ-020 multu: {HI,LO} = unsigned(A) * unsigned(B), full 64-bit product.
REQ-021 div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-022 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 divu: LO = A / B and HI = A % B, both unsigned.
REQ-024 Divide by zero (B=0 for div or divu):
- the full 10-cycle busy period SHALL still run;
- HI and LO SHALL stay unchanged at completion.
REQ-025 start while busy=1 SHALL be ignored, with no restart and no change to the latched operands.
REQ-026 load_HI or load_LO while busy=1 and start=0 SHALL write load_value at that edge.
REQ-027 A load accepted under REQ-026 SHALL then be overwritten by the pending operation's result at completion, except after divide by zero.
REQ-028 start and load_HI/load_LO in the same cycle, from IDLE: the operation SHALL be accepted and the load SHALL be ignored.
REQ-029 load_HI and load_LO together SHALL write both registers with load_value.
REQ-030 In the completion cycle (busy=1, counter=N-1), a new start SHALL be ignored under REQ-025.
REQ-031 busy_any SHALL be purely combinational and SHALL have no dependence on A, B or op.

Reset
REQ-032 reset_n=0 SHALL immediately force state=IDLE, counter=0, busy=0, HI=0 and LO=0, independent of clk.
REQ-033 reset_n asserted mid-operation SHALL abort the operation; no result SHALL be written after release.
REQ-034 The first accepted start SHALL be the first edge after reset_n rises with start=1.

Verification
REQ-035 mult, A=0xFFFFFFFE (-2), B=3, start at edge 0 -> busy=1 in cycles 1-5; cycle 6: busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 Two divisions, each checked after 10 busy cycles:
- div, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF;
- divu, A=7, B=0 -> HI and LO keep their prior values (0x11111111 and 0x22222222).
REQ-038 Start during busy: div started, then a second start with op=mult at cycle 3 -> the second start is ignored and busy falls after exactly 10 cycles with the div result.
REQ-039 Load during busy: load_LO with load_value=0x12345678 at cycle 2 of mult 3*4 -> LO=0x12345678 in cycles 3-5; at cycle 6, LO=0x0000000C.
REQ-040 Reset mid-operation: reset_n pulsed low at cycle 4 of div 100/7 -> busy=0, HI=LO=0 immediately, and they remain 0 after release with no start.
